// File: rtl/sdischg_ctl.sv
// Soft-discharge controller: VBUS/VIN discharge switch drive with a shared 32-step PWM timebase and OTP gating.
// Define SDISCHG_VIN_EN to build the VIN channel; without it vin_dischg is tied low.
module sdischg_ctl #(
  parameter int unsigned STEP_CYC = 100
) (
  input  logic       clk,
  input  logic       srstz,
  input  logic       vbus_dis_req,
  input  logic       vin_dis_req,
  input  logic [6:0] r_sdischg,
  input  logic       otpi,
  input  logic       otpi_gate,
  output logic       vbus_dischg,
  output logic       vin_dischg,
  output logic       sdischg_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_FULL, ST_SOFT} ch_state_t;

  localparam logic [9:0] PRE_MAX = 10'(STEP_CYC - 1);

  ch_state_t  vbus_st_q, vbus_st_d;
  ch_state_t  vin_st_q;
  logic [9:0] presc_q, presc_d;
  logic [4:0] step_q, step_d;
  logic [4:0] vbus_duty_q, vbus_duty_d;
  logic [4:0] duty;
  logic       otpi_s1_q, otpi_s2_q;
  logic       soft_any, tick, wrap, gated;
  logic       vbus_out_d;

  assign duty = r_sdischg[4:0];

  // Mode is chosen on request, then only re-evaluated at the period boundary.
  function automatic ch_state_t ch_next(ch_state_t st, logic req, logic soft_en,
                                        logic [4:0] d, logic at_wrap);
    ch_state_t nxt;
    nxt = st;
    if (!req)
      nxt = ST_IDLE;
    else if (st == ST_IDLE || at_wrap) begin
      if (soft_en && d != 5'd31)
        nxt = ST_SOFT;
      else
        nxt = ST_FULL;
    end
    return nxt;
  endfunction

  function automatic logic ch_drive(ch_state_t st, logic [4:0] phase, logic [4:0] d);
    return (st == ST_FULL) || (st == ST_SOFT && phase <= d);
  endfunction

  assign soft_any     = (vbus_st_q == ST_SOFT) || (vin_st_q == ST_SOFT);
  assign tick         = soft_any && (presc_q == PRE_MAX);
  assign wrap         = tick && (step_q == 5'd31);
  assign gated        = otpi_gate && otpi_s2_q;
  assign sdischg_busy = (vbus_st_q != ST_IDLE) || (vin_st_q != ST_IDLE);

  // Timebase is parked at zero until some channel runs soft, so the first entry starts a fresh period.
  always_comb begin
    presc_d = '0;
    step_d  = '0;
    if (soft_any) begin
      presc_d = tick ? 10'd0 : presc_q + 10'd1;
      step_d  = tick ? step_q + 5'd1 : step_q;
    end
  end

  always_comb begin
    vbus_st_d   = ch_next(vbus_st_q, vbus_dis_req, r_sdischg[6], duty, wrap);
    vbus_duty_d = vbus_duty_q;
    if (vbus_st_d == ST_SOFT && (vbus_st_q != ST_SOFT || wrap))
      vbus_duty_d = duty;
    vbus_out_d  = ch_drive(vbus_st_d, step_d, vbus_duty_d) && !gated;
  end

  always_ff @(posedge clk or negedge srstz) begin
    if (!srstz) begin
      vbus_st_q   <= ST_IDLE;
      presc_q     <= '0;
      step_q      <= '0;
      vbus_duty_q <= '0;
      otpi_s1_q   <= 1'b0;
      otpi_s2_q   <= 1'b0;
      vbus_dischg <= 1'b0;
    end else begin
      vbus_st_q   <= vbus_st_d;
      presc_q     <= presc_d;
      step_q      <= step_d;
      vbus_duty_q <= vbus_duty_d;
      otpi_s1_q   <= otpi;
      otpi_s2_q   <= otpi_s1_q;
      vbus_dischg <= vbus_out_d;
    end
  end

`ifdef SDISCHG_VIN_EN
  ch_state_t  vin_st_d;
  logic [4:0] vin_duty_q, vin_duty_d;
  logic       vin_out_d;

  // VIN runs half a period behind VBUS on the same timebase.
  always_comb begin
    vin_st_d   = ch_next(vin_st_q, vin_dis_req, r_sdischg[5], duty, wrap);
    vin_duty_d = vin_duty_q;
    if (vin_st_d == ST_SOFT && (vin_st_q != ST_SOFT || wrap))
      vin_duty_d = duty;
    vin_out_d  = ch_drive(vin_st_d, step_d + 5'd16, vin_duty_d) && !gated;
  end

  always_ff @(posedge clk or negedge srstz) begin
    if (!srstz) begin
      vin_st_q   <= ST_IDLE;
      vin_duty_q <= '0;
      vin_dischg <= 1'b0;
    end else begin
      vin_st_q   <= vin_st_d;
      vin_duty_q <= vin_duty_d;
      vin_dischg <= vin_out_d;
    end
  end
`else
  logic vin_unused;

  assign vin_st_q   = ST_IDLE;
  assign vin_dischg = 1'b0;
  assign vin_unused = ^{vin_dis_req, r_sdischg[5]};
`endif

endmodule

// File: tb/tb_sdischg_ctl.sv
// Directed bench for sdischg_ctl: vector table for static behaviour, hand sequences for PWM timing,
// OTP gating, mid-period duty writes and asynchronous reset.
module tb_sdischg_ctl;

  localparam int unsigned STEP      = 10;
  localparam int          RUN_LIMIT = 2000;
`ifdef SDISCHG_VIN_EN
  localparam logic VIN_EN = 1'b1;
`else
  localparam logic VIN_EN = 1'b0;
`endif

  typedef struct {
    logic       vbus_req;
    logic       vin_req;
    logic [6:0] r;
    logic       otpi;
    logic       gate;
    int         cycles;
    logic       exp_vbus;
    logic       exp_vin;
    logic       exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       srstz;
  logic       vbus_dis_req, vin_dis_req;
  logic [6:0] r_sdischg;
  logic       otpi, otpi_gate;
  logic       vbus_dischg, vin_dischg, sdischg_busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[13];

  sdischg_ctl #(.STEP_CYC(STEP)) dut (
    .clk          (clk),
    .srstz        (srstz),
    .vbus_dis_req (vbus_dis_req),
    .vin_dis_req  (vin_dis_req),
    .r_sdischg    (r_sdischg),
    .otpi         (otpi),
    .otpi_gate    (otpi_gate),
    .vbus_dischg  (vbus_dischg),
    .vin_dischg   (vin_dischg),
    .sdischg_busy (sdischg_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    vbus_dis_req = v.vbus_req;
    vin_dis_req  = v.vin_req;
    r_sdischg    = v.r;
    otpi         = v.otpi;
    otpi_gate    = v.gate;
    repeat (v.cycles) @(negedge clk);
  endtask

  task automatic goIdle();
    vbus_dis_req = 1'b0;
    vin_dis_req  = 1'b0;
    r_sdischg    = 7'h00;
    otpi         = 1'b0;
    otpi_gate    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic outOf(input int ch);
    return (ch == 0) ? vbus_dischg : vin_dischg;
  endfunction

  // Counts consecutive negedge samples at level lvl, starting with the current one.
  task automatic measureRun(input int ch, input logic lvl, output int len);
    len = 0;
    while (outOf(ch) == lvl && len < RUN_LIMIT) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int len, len1, elapsed;

    //          vbus  vin   r      otpi  gate  cyc  vbus  vin     busy
    vecs[0]  = '{1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1,   1'b1, 1'b0,   1'b1};
    vecs[1]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1,   1'b0, 1'b0,   1'b0};
    vecs[2]  = '{1'b1, 1'b0, 7'h5F, 1'b0, 1'b0, 1,   1'b1, 1'b0,   1'b1};
    vecs[3]  = '{1'b1, 1'b0, 7'h5F, 1'b0, 1'b0, 400, 1'b1, 1'b0,   1'b1};
    vecs[4]  = '{1'b0, 1'b0, 7'h5F, 1'b0, 1'b0, 1,   1'b0, 1'b0,   1'b0};
    vecs[5]  = '{1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 3,   1'b1, 1'b0,   1'b1};
    vecs[6]  = '{1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 3,   1'b0, 1'b0,   1'b1};
    vecs[7]  = '{1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 3,   1'b1, 1'b0,   1'b1};
    vecs[8]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1,   1'b0, 1'b0,   1'b0};
    vecs[9]  = '{1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 1,   1'b0, VIN_EN, VIN_EN};
    vecs[10] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1,   1'b0, 1'b0,   1'b0};
    vecs[11] = '{1'b1, 1'b1, 7'h00, 1'b0, 1'b0, 1,   1'b1, VIN_EN, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1,   1'b0, 1'b0,   1'b0};

    srstz = 1'b0;
    vbus_dis_req = 1'b0;
    vin_dis_req  = 1'b0;
    r_sdischg    = 7'h00;
    otpi         = 1'b0;
    otpi_gate    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_vbus", vbus_dischg, 0);
    checkOutput("reset_vin", vin_dischg, 0);
    checkOutput("reset_busy", sdischg_busy, 0);
    srstz = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_vbus", i), vbus_dischg, vecs[i].exp_vbus);
      checkOutput($sformatf("vec%0d_vin", i), vin_dischg, vecs[i].exp_vin);
      checkOutput($sformatf("vec%0d_busy", i), sdischg_busy, vecs[i].exp_busy);
    end

    // Duty 1: 20 cycles high, 300 low, repeating.
    goIdle();
    r_sdischg = 7'h41;
    vbus_dis_req = 1'b1;
    @(negedge clk);
    checkOutput("soft1_first", vbus_dischg, 1);
    measureRun(0, 1'b1, len);
    checkOutput("soft1_high", len, 20);
    measureRun(0, 1'b0, len);
    checkOutput("soft1_low", len, 300);
    measureRun(0, 1'b1, len);
    checkOutput("soft1_high2", len, 20);

    // Duty 2 -> 20 written during the pulse: current pulse 30, next 210.
    goIdle();
    r_sdischg = 7'h42;
    vbus_dis_req = 1'b1;
    @(negedge clk);
    len1 = 0;
    repeat (10) begin
      if (vbus_dischg) len1++;
      @(negedge clk);
    end
    r_sdischg = 7'h54;
    measureRun(0, 1'b1, len);
    checkOutput("dutychg_cur_high", len1 + len, 30);
    measureRun(0, 1'b0, len);
    checkOutput("dutychg_low", len, 290);
    measureRun(0, 1'b1, len);
    checkOutput("dutychg_next_high", len, 210);

    // OTP gating inside a duty-15 pulse, then release without restarting the period.
    goIdle();
    r_sdischg = 7'h4F;
    vbus_dis_req = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    otpi = 1'b1;
    otpi_gate = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("otp_gated_vbus", vbus_dischg, 0);
    checkOutput("otp_gated_busy", sdischg_busy, 1);
    repeat (42) @(negedge clk);
    otpi = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("otp_release_vbus", vbus_dischg, 1);
    measureRun(0, 1'b1, len);
    checkOutput("otp_release_rest_high", len, 108);
    measureRun(0, 1'b0, len);
    checkOutput("otp_release_low", len, 160);

    // Asynchronous reset in the middle of a pulse, request held.
    goIdle();
    r_sdischg = 7'h4F;
    vbus_dis_req = 1'b1;
    @(negedge clk);
    repeat (19) @(negedge clk);
    checkOutput("rst_pre_vbus", vbus_dischg, 1);
    srstz = 1'b0;
    #1;
    checkOutput("rst_async_vbus", vbus_dischg, 0);
    checkOutput("rst_async_busy", sdischg_busy, 0);
    @(negedge clk);
    srstz = 1'b1;
    @(negedge clk);
    checkOutput("rst_restart_first", vbus_dischg, 1);
    measureRun(0, 1'b1, len);
    checkOutput("rst_restart_high", len, 160);

`ifdef SDISCHG_VIN_EN
    // Both channels soft, duty 2: 30-cycle pulses, VIN rising 160 cycles after VBUS.
    goIdle();
    r_sdischg = 7'h62;
    vbus_dis_req = 1'b1;
    vin_dis_req = 1'b1;
    @(negedge clk);
    checkOutput("dual_vbus_first", vbus_dischg, 1);
    checkOutput("dual_vin_first", vin_dischg, 0);
    measureRun(0, 1'b1, len);
    checkOutput("dual_vbus_high", len, 30);
    elapsed = 1 + len;
    while (!vin_dischg && elapsed < RUN_LIMIT) begin
      elapsed++;
      @(negedge clk);
    end
    checkOutput("dual_vin_offset", elapsed - 1, 160);
    measureRun(1, 1'b1, len);
    checkOutput("dual_vin_high", len, 30);
`endif

    goIdle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
